// File: rtl/axi_lite_arbiter.sv
// 2:1 AXI-lite arbiter: IFU (read-only) and LSU (read/write) share one slave port.
// One transaction in flight. The grant is held until the R or B handshake completes.
// Optional macro ARB_RR_EN: round-robin between the IFU and LSU classes.
// Without ARB_RR_EN the priority is fixed: LSU write > LSU read > IFU read.
module axi_lite_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // IFU read channels
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  // LSU read channels
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  // LSU write channels
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  output logic              lsu_awready,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [STRB_W-1:0] lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic [1:0]        lsu_bresp,
  output logic              lsu_bvalid,
  input  logic              lsu_bready,
  // Slave port
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic [1:0]        arb_state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRdIfu = 2'd1,
    StRdLsu = 2'd2,
    StWrLsu = 2'd3
  } state_e;

  state_e state_q, state_d;

  assign arb_state = state_q;

`ifdef ARB_RR_EN
  // 0: IFU was granted last, 1: LSU was granted last
  logic last_grant_q, last_grant_d;
`endif

  // Next-state: arbitrate in idle, release the grant on the final response handshake
  always_comb begin
    state_d = state_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef ARB_RR_EN
        // LSU class wins unless it was granted last and the IFU is waiting
        if ((lsu_awvalid || lsu_arvalid) && (!ifu_arvalid || !last_grant_q)) begin
          state_d      = lsu_awvalid ? StWrLsu : StRdLsu;
          last_grant_d = 1'b1;
        end else if (ifu_arvalid) begin
          state_d      = StRdIfu;
          last_grant_d = 1'b0;
        end
`else
        if (lsu_awvalid)      state_d = StWrLsu;
        else if (lsu_arvalid) state_d = StRdLsu;
        else if (ifu_arvalid) state_d = StRdIfu;
`endif
      end
      StRdIfu, StRdLsu: if (s_rvalid && s_rready) state_d = StIdle;
      StWrLsu:          if (s_bvalid && s_bready) state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  // Channel mux: only the granted master's channels reach the slave
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = '0;
    lsu_bvalid  = 1'b0;
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awaddr    = '0;
    s_awvalid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    unique case (state_q)
      StRdIfu: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid;
        ifu_arready = s_arready;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
        ifu_rvalid  = s_rvalid;
        s_rready    = ifu_rready;
      end
      StRdLsu: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid;
        lsu_arready = s_arready;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
        lsu_rvalid  = s_rvalid;
        s_rready    = lsu_rready;
      end
      StWrLsu: begin
        // AW and W pass independently; the slave may accept either first
        s_awaddr    = lsu_awaddr;
        s_awvalid   = lsu_awvalid;
        lsu_awready = s_awready;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        s_wvalid    = lsu_wvalid;
        lsu_wready  = s_wready;
        lsu_bresp   = s_bresp;
        lsu_bvalid  = s_bvalid;
        s_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter.
module tb_axi_lite_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
  logic [7:0]  lsu_wstrb, s_wstrb;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_rresp, s_bresp, arb_state;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .arb_state(arb_state)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
    lsu_wvalid = 0;  lsu_bready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    n_cmp++;
    if (arb_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", arb_state);
    end
    n_cmp++;
    if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_slave_ctrl: got %b want 00000",
                         {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready});
    end
    rst = 0;
  endtask

  task automatic test_ifu_alone();
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1; s_arready = 1;
    #1;
    n_cmp++;
    if (s_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_idle_no_fwd: got s_arvalid=%b want 0", s_arvalid);
    end
    tick();
    n_cmp++;
    if (arb_state !== 2'd1 || s_araddr !== 32'h8000_0000 || ifu_arready !== 1'b1) begin
      n_fail++; $display("FAIL ifu_grant: got st=%0d addr=%h rdy=%b want 1 80000000 1",
                         arb_state, s_araddr, ifu_arready);
    end
    tick();
    ifu_arvalid = 0; s_arready = 0;
    tick();
    s_rvalid = 1; s_rdata = 32'h0000_0413; ifu_rready = 1;
    #1;
    n_cmp++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || lsu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_rdata: got v=%b d=%h lsu_v=%b want 1 00000413 0",
                         ifu_rvalid, ifu_rdata, lsu_rvalid);
    end
    tick();
    clear_inputs();
    n_cmp++;
    if (arb_state !== 2'd0) begin
      n_fail++; $display("FAIL ifu_done_idle: got %0d want 0", arb_state);
    end
  endtask

  task automatic test_same_cycle();
    ifu_araddr = 32'h8000_0040; ifu_arvalid = 1;
    lsu_araddr = 32'h8000_2000; lsu_arvalid = 1;
    tick();
    s_arready = 1;
    #1;
    n_cmp++;
    if (arb_state !== 2'd2 || lsu_arready !== 1'b1 || ifu_arready !== 1'b0
        || s_araddr !== 32'h8000_2000) begin
      n_fail++; $display("FAIL prio_lsu_first: got st=%0d lrdy=%b irdy=%b addr=%h want 2 1 0 80002000",
                         arb_state, lsu_arready, ifu_arready, s_araddr);
    end
    tick();
    lsu_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h1111_2222; lsu_rready = 1; ifu_rready = 1;
    #1;
    n_cmp++;
    if (lsu_rvalid !== 1'b1 || ifu_rvalid !== 1'b0 || ifu_rdata !== 32'h0) begin
      n_fail++; $display("FAIL prio_lsu_r: got lv=%b iv=%b idata=%h want 1 0 0",
                         lsu_rvalid, ifu_rvalid, ifu_rdata);
    end
    tick();
    s_rvalid = 0; s_arready = 1;
    #1;
    n_cmp++;
    if (arb_state !== 2'd0 || ifu_arready !== 1'b0) begin
      n_fail++; $display("FAIL prio_gap: got st=%0d irdy=%b want 0 0", arb_state, ifu_arready);
    end
    tick();
    n_cmp++;
    if (arb_state !== 2'd1 || ifu_arready !== 1'b1 || s_araddr !== 32'h8000_0040) begin
      n_fail++; $display("FAIL prio_ifu_next: got st=%0d irdy=%b addr=%h want 1 1 80000040",
                         arb_state, ifu_arready, s_araddr);
    end
    tick();
    ifu_arvalid = 0; s_arready = 0; s_rvalid = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_write();
    lsu_awaddr = 32'h8000_1000; lsu_awvalid = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 8'h0F; lsu_wvalid = 1; lsu_bready = 1;
    tick();
    s_wready = 1;
    #1;
    n_cmp++;
    if (arb_state !== 2'd3 || lsu_wready !== 1'b1 || lsu_awready !== 1'b0
        || s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 8'h0F) begin
      n_fail++; $display("FAIL wr_w_first: got st=%0d wrdy=%b awrdy=%b d=%h s=%h want 3 1 0 deadbeef 0f",
                         arb_state, lsu_wready, lsu_awready, s_wdata, s_wstrb);
    end
    tick();
    lsu_wvalid = 0; s_wready = 0;
    tick();
    tick();
    s_awready = 1;
    #1;
    n_cmp++;
    if (s_awvalid !== 1'b1 || lsu_awready !== 1'b1 || s_awaddr !== 32'h8000_1000) begin
      n_fail++; $display("FAIL wr_aw_late: got v=%b rdy=%b addr=%h want 1 1 80001000",
                         s_awvalid, lsu_awready, s_awaddr);
    end
    tick();
    lsu_awvalid = 0; s_awready = 0; s_bvalid = 1; ifu_rready = 1;
    #1;
    n_cmp++;
    if (lsu_bvalid !== 1'b1 || s_bready !== 1'b1 || ifu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_b: got bv=%b bready=%b irv=%b want 1 1 0",
                         lsu_bvalid, s_bready, ifu_rvalid);
    end
    tick();
    clear_inputs();
    n_cmp++;
    if (arb_state !== 2'd0) begin
      n_fail++; $display("FAIL wr_done_idle: got %0d want 0", arb_state);
    end
  endtask

  task automatic test_err_resp();
    lsu_araddr = 32'h8000_3000; lsu_arvalid = 1; s_arready = 1;
    tick();
    tick();
    lsu_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rresp = 2'b10; s_rdata = 32'h55; lsu_rready = 1;
    #1;
    n_cmp++;
    if (lsu_rresp !== 2'b10 || lsu_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL err_rresp: got resp=%b v=%b want 10 1", lsu_rresp, lsu_rvalid);
    end
    tick();
    clear_inputs();
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1;
    #1;
    n_cmp++;
    if (arb_state !== 2'd0 || lsu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL err_idle: got st=%0d v=%b want 0 0", arb_state, lsu_rvalid);
    end
    tick();
    n_cmp++;
    if (arb_state !== 2'd1 || s_araddr !== 32'h8000_0004) begin
      n_fail++; $display("FAIL err_next: got st=%0d addr=%h want 1 80000004", arb_state, s_araddr);
    end
    s_rvalid = 1; ifu_rready = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [1:0] want [4];
`ifdef ARB_RR_EN
    want = '{2'd2, 2'd1, 2'd2, 2'd1};
`else
    want = '{2'd2, 2'd2, 2'd2, 2'd2};
`endif
    ifu_araddr = 32'h8000_0100; ifu_arvalid = 1;
    lsu_araddr = 32'h8000_4000; lsu_arvalid = 1;
    ifu_rready = 1; lsu_rready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (arb_state !== want[i]) begin
        n_fail++; $display("FAIL b2b_grant%0d: got %0d want %0d", i, arb_state, want[i]);
      end
      s_arready = 1;
      tick();
      s_arready = 0; s_rvalid = 1;
      tick();
      s_rvalid = 0;
    end
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    ifu_araddr = 32'h8000_0200; ifu_arvalid = 1;
    tick();
    n_cmp++;
    if (arb_state !== 2'd1 || s_arvalid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: got st=%0d arv=%b want 1 1", arb_state, s_arvalid);
    end
    rst = 1; s_rvalid = 1; ifu_rready = 1;
    tick();
    n_cmp++;
    if (arb_state !== 2'd0 || s_arvalid !== 1'b0 || s_awvalid !== 1'b0
        || s_wvalid !== 1'b0 || ifu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got st=%0d arv=%b awv=%b wv=%b irv=%b want 0 0 0 0 0",
                         arb_state, s_arvalid, s_awvalid, s_wvalid, ifu_rvalid);
    end
    rst = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_ifu_alone();
    test_same_cycle();
    test_write();
    test_err_resp();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
